// File: rtl/retire_free_controller.sv
// -----------------------------------------------------------------------------
// retire_free_controller
//
// In-order retire scheduler for the 2-wide pipeline. Rename allocates up to two
// reorder-buffer entries per cycle at the tail, writeback marks entries done,
// and up to two done entries retire per cycle from the head, oldest first.
// Each retire hands the entry's superseded physical register back to the
// renamer through the registered en_free_reg*/free_reg* outputs.
//
// Optional feature macro: RETIRE_STATS_EN
//   When defined, adds retired_cnt_o (total entries retired) and stall_cnt_o
//   (cycles with an alloc request while alloc_ready_o is low). Both are 32-bit
//   wrapping counters cleared by reset.
//
// Ports:
//   clk_i, rst_n_i                 clock, synchronous active-low reset
//   alloc0_i/alloc1_i              allocate request, rename slot 0/1
//   has_dest0_i/has_dest1_i        slot writes a register (free old one later)
//   old_dest0_i/old_dest1_i        superseded physical register per slot
//   alloc_ready_o                  at least two entries free
//   rob_idx0_o/rob_idx1_o          index each slot receives if allocated now
//   complete_en*_i/complete_idx*_i writeback completion strobes and indices
//   en_free_reg*_o/free_reg*_o     registered free-register outputs
//   count_o, empty_o               occupancy, occupancy == 0
// -----------------------------------------------------------------------------
module retire_free_controller #(
  parameter int  NUM_P_REGS = 64,
  parameter int  ROB_DEPTH  = 16,
  localparam int PW         = $clog2(NUM_P_REGS),
  localparam int IW         = $clog2(ROB_DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          alloc0_i,
  input  logic          alloc1_i,
  input  logic          has_dest0_i,
  input  logic          has_dest1_i,
  input  logic [PW-1:0] old_dest0_i,
  input  logic [PW-1:0] old_dest1_i,
  output logic          alloc_ready_o,
  output logic [IW-1:0] rob_idx0_o,
  output logic [IW-1:0] rob_idx1_o,
  input  logic          complete_en0_i,
  input  logic          complete_en1_i,
  input  logic [IW-1:0] complete_idx0_i,
  input  logic [IW-1:0] complete_idx1_i,
  output logic          en_free_reg0_o,
  output logic          en_free_reg1_o,
  output logic [PW-1:0] free_reg0_o,
  output logic [PW-1:0] free_reg1_o,
  output logic [IW:0]   count_o,
  output logic          empty_o
`ifdef RETIRE_STATS_EN
  ,
  output logic [31:0]   retired_cnt_o,
  output logic [31:0]   stall_cnt_o
`endif
);

  // Allocation needs two free entries, i.e. count <= ROB_DEPTH-2.
  localparam logic [IW:0]   READY_MAX = (IW+1)'(ROB_DEPTH - 2);
  localparam logic [IW-1:0] ONE_IDX   = IW'(1);

  // Entry storage
  logic [ROB_DEPTH-1:0] valid_q, valid_d;
  logic [ROB_DEPTH-1:0] done_q, done_d;
  logic [ROB_DEPTH-1:0] has_dest_q, has_dest_d;
  logic [PW-1:0]        old_dest_q [ROB_DEPTH];
  logic [PW-1:0]        old_dest_d [ROB_DEPTH];

  // Pointers and occupancy
  logic [IW-1:0] head_q, head_d;
  logic [IW-1:0] tail_q, tail_d;
  logic [IW:0]   count_q, count_d;

  // Registered free outputs
  logic          en_free0_q, en_free0_d;
  logic          en_free1_q, en_free1_d;
  logic [PW-1:0] free_reg0_q, free_reg0_d;
  logic [PW-1:0] free_reg1_q, free_reg1_d;

  // Internal combinational signals
  logic          ready_s;
  logic          acc0_s, acc1_s;
  logic [IW-1:0] idx1_s;
  logic [IW-1:0] head1_s;
  logic          r0_s, r1_s;
  logic [IW-1:0] tail_adv_s, head_adv_s;

`ifdef RETIRE_STATS_EN
  logic [31:0] retired_q, retired_d;
  logic [31:0] stall_q, stall_d;
`endif

  // Allocation readiness, slot packing and retire decision.
  always_comb begin
    ready_s    = (count_q <= READY_MAX);
    acc0_s     = alloc0_i & ready_s;
    acc1_s     = alloc1_i & ready_s;
    // Slot 1 packs directly behind slot 0 only when slot 0 is used.
    idx1_s     = alloc0_i ? (tail_q + ONE_IDX) : tail_q;
    head1_s    = head_q + ONE_IDX;
    // An empty buffer has valid[head] = 0, so no retire can happen.
    r0_s       = valid_q[head_q] & done_q[head_q];
    r1_s       = r0_s & valid_q[head1_s] & done_q[head1_s];
    tail_adv_s = {{(IW-1){1'b0}}, acc0_s} + {{(IW-1){1'b0}}, acc1_s};
    head_adv_s = {{(IW-1){1'b0}}, r0_s} + {{(IW-1){1'b0}}, r1_s};
  end

  // Entry next-state: completions, then retire clears, then allocation writes.
  always_comb begin
    valid_d    = valid_q;
    done_d     = done_q;
    has_dest_d = has_dest_q;
    old_dest_d = old_dest_q;

    // Completions only land on entries already valid at the start of the cycle.
    done_d[complete_idx0_i] = done_d[complete_idx0_i] |
                              (complete_en0_i & valid_q[complete_idx0_i]);
    done_d[complete_idx1_i] = done_d[complete_idx1_i] |
                              (complete_en1_i & valid_q[complete_idx1_i]);

    valid_d[head_q]  = valid_d[head_q] & ~r0_s;
    done_d[head_q]   = done_d[head_q] & ~r0_s;
    valid_d[head1_s] = valid_d[head1_s] & ~r1_s;
    done_d[head1_s]  = done_d[head1_s] & ~r1_s;

    // Allocation never targets a retiring entry: it needs two free slots.
    valid_d[tail_q]    = valid_d[tail_q] | acc0_s;
    done_d[tail_q]     = done_d[tail_q] & ~acc0_s;
    has_dest_d[tail_q] = acc0_s ? has_dest0_i : has_dest_d[tail_q];
    old_dest_d[tail_q] = acc0_s ? old_dest0_i : old_dest_d[tail_q];

    valid_d[idx1_s]    = valid_d[idx1_s] | acc1_s;
    done_d[idx1_s]     = done_d[idx1_s] & ~acc1_s;
    has_dest_d[idx1_s] = acc1_s ? has_dest1_i : has_dest_d[idx1_s];
    old_dest_d[idx1_s] = acc1_s ? old_dest1_i : old_dest_d[idx1_s];
  end

  // Pointer, occupancy and free-output next-state.
  always_comb begin
    tail_d      = tail_q + tail_adv_s;
    head_d      = head_q + head_adv_s;
    count_d     = count_q + {1'b0, tail_adv_s} - {1'b0, head_adv_s};
    en_free0_d  = r0_s & has_dest_q[head_q];
    en_free1_d  = r1_s & has_dest_q[head1_s];
    free_reg0_d = r0_s ? old_dest_q[head_q] : {PW{1'b0}};
    free_reg1_d = r1_s ? old_dest_q[head1_s] : {PW{1'b0}};
  end

`ifdef RETIRE_STATS_EN
  // Statistics counter next-state; both wrap naturally at 2^32.
  always_comb begin
    retired_d = retired_q + {31'd0, r0_s} + {31'd0, r1_s};
    stall_d   = stall_q + {31'd0, (alloc0_i | alloc1_i) & ~ready_s};
  end

  // Statistics counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      retired_q <= 32'd0;
      stall_q   <= 32'd0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign retired_cnt_o = retired_q;
  assign stall_cnt_o   = stall_q;
`endif

  // State registers; reset discards in-flight entries without freeing them.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q     <= {ROB_DEPTH{1'b0}};
      done_q      <= {ROB_DEPTH{1'b0}};
      has_dest_q  <= {ROB_DEPTH{1'b0}};
      for (int i = 0; i < ROB_DEPTH; i++) begin
        old_dest_q[i] <= {PW{1'b0}};
      end
      head_q      <= {IW{1'b0}};
      tail_q      <= {IW{1'b0}};
      count_q     <= {(IW+1){1'b0}};
      en_free0_q  <= 1'b0;
      en_free1_q  <= 1'b0;
      free_reg0_q <= {PW{1'b0}};
      free_reg1_q <= {PW{1'b0}};
    end else begin
      valid_q     <= valid_d;
      done_q      <= done_d;
      has_dest_q  <= has_dest_d;
      old_dest_q  <= old_dest_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      en_free0_q  <= en_free0_d;
      en_free1_q  <= en_free1_d;
      free_reg0_q <= free_reg0_d;
      free_reg1_q <= free_reg1_d;
    end
  end

  assign alloc_ready_o  = ready_s;
  assign rob_idx0_o     = tail_q;
  assign rob_idx1_o     = idx1_s;
  assign count_o        = count_q;
  assign empty_o        = (count_q == {(IW+1){1'b0}});
  assign en_free_reg0_o = en_free0_q;
  assign en_free_reg1_o = en_free1_q;
  assign free_reg0_o    = free_reg0_q;
  assign free_reg1_o    = free_reg1_q;

endmodule
